pipelined_add_sub: RTL and testbench
====================================

// Module: pipelined_add_sub
// PURPOSE
//  Parametrised, pipelined two's-complement adder/subtractor; successor of the 8-bit ripple add/sub.
//  Splits a WIDTH-bit add/sub into STAGES carry-chained slices, one slice per cycle, with valid/ready flow.
//  Adds optional signed saturation and carry/overflow/zero/negative flags. Feeds the ALU result mux.
// PARAMETERS
//  WIDTH   32  operand/result width; must be a multiple of STAGES
//  STAGES  4   pipeline depth = number of slices; SLICE = WIDTH/STAGES bits per slice
// PORTS
//  i_clk       in   1      clock, all logic on rising edge
//  i_rst_n     in   1      asynchronous, active-low reset
//  i_valid     in   1      input operands valid
//  o_ready     out  1      block accepts input this cycle
//  i_a         in   WIDTH  operand A
//  i_b         in   WIDTH  operand B
//  i_sub       in   1      0: A+B, 1: A-B (B inverted, carry-in 1)
//  i_sat       in   1      1: clamp result on signed overflow
//  o_valid     out  1      result valid
//  i_ready     in   1      downstream accepts result
//  o_result    out  WIDTH  result (saturated if i_sat and overflow)
//  o_carry     out  1      carry out of MSB (for subtract: 1 = no borrow)
//  o_ovf       out  1      signed overflow, pre-saturation = cout(MSB) ^ cin(MSB)
//  o_zero      out  1      o_result == 0 (post-saturation)
//  o_neg       out  1      o_result[WIDTH-1] (post-saturation)
// BEHAVIOUR
//  - Reset (async, i_rst_n=0): all stage valid bits 0; o_valid=0; o_result, flags = 0; o_ready=1 after release.
//  - Global stall: adv = ~o_valid | i_ready; o_ready = adv. Transfer in when i_valid & o_ready; out when o_valid & i_ready.
//  - When adv=0 every stage register holds (data, valid, carry); nothing is lost or duplicated.
//  - Latency exactly STAGES cycles from accepted input to o_valid at full throughput; 1 result/cycle sustained.
//  - Stage k (0..STAGES-1) adds slice k of A and B^{SLICE{sub}} with carry from stage k-1 (stage 0: cin = i_sub).
//  - Operand slices above k travel skewed in stage registers; finished lower slices travel alongside; sub/sat bits ride along.
//  - Final stage: compute cout, cin into MSB, ovf; if sat & ovf: result = A_sign ? {1,0..0} (min) : {0,1..1} (max);
//    A_sign is the sign of the original A (equals sign of effective B when overflow occurs).
//  - Bubbles (i_valid=0 while adv=1) propagate as valid=0 stages; outputs hold last value while o_valid=0 is allowed but not required.
//  - Simultaneous i_valid & i_ready with full pipe: one in, one out same cycle.
//  - Reset mid-operation: all in-flight operations discarded, no o_valid after reset release until new input has traversed STAGES cycles.
//  - Wrap-around: unsigned result is modulo 2^WIDTH when i_sat=0; o_carry reports it.
//  - STAGES=1 degenerates to single registered add/sub, latency 1.
// STRUCTURE
//  - Package add_sub_pkg: typedef enum logic {OP_ADD=0, OP_SUB=1} op_e; localparam function sat_max/sat_min(WIDTH).
//  - Sub-module add_sub_slice #(SLICE): combinational SLICE-bit adder, ports a, b, cin, sum, cout, cin_msb
//    (carry into its top bit, used by last slice for ovf). Built from existing full_adder cells or '+'.
//  - Top: generate loop of STAGES stage registers + slices; shared adv enable; flag/saturation logic in last stage.
// TESTING (WIDTH=8, STAGES=2 unless noted)
//  1. i_a=0x05,i_b=0x03,sub=0,sat=0 -> after 2 cycles result 0x08, carry 0, ovf 0, zero 0, neg 0.
//  2. i_a=0x7F,i_b=0x01,sub=0: sat=0 -> 0x80, ovf 1, neg 1; sat=1 -> 0x7F, ovf 1, neg 0.
//  3. i_a=0x80,i_b=0x01,sub=1: sat=0 -> 0x7F, carry 1, ovf 1; sat=1 -> 0x80. i_a=0x03,i_b=0x03,sub=1 -> 0x00, zero 1, carry 1.
//  4. Stream 20 random ops, i_ready toggled pseudo-randomly -> outputs in order, match reference model, none dropped/duplicated.
//  5. Fill pipe, assert i_rst_n=0 for 1 cycle mid-stream -> o_valid=0 immediately; next result only from post-reset inputs.
//  6. WIDTH=32,STAGES=4: 0xFFFFFFFF+0x00000001 -> 0x00000000, carry 1, zero 1, latency 4; back-to-back throughput 1/cycle.

Source files
------------

// File: rtl/add_sub_pkg.sv
// Shared types and saturation constants for the pipelined adder/subtractor.
package add_sub_pkg;
  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;

  localparam int MAX_W = 64;

  // Widest representable signed values for a w-bit word; callers truncate to w bits.
  function automatic logic [MAX_W-1:0] sat_max(input int w);
    return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] sat_min(input int w);
    return MAX_W'(1) << (w - 1);
  endfunction
endpackage

// File: rtl/add_sub_slice.sv
// Combinational ripple adder for one slice; also exposes the carry into its top bit.
module add_sub_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             cin_msb
);
  always_comb begin
    logic c;
    c       = cin;
    sum     = '0;
    cin_msb = 1'b0;
    for (int i = 0; i < SLICE; i++) begin
      if (i == SLICE - 1) cin_msb = c;
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end
endmodule

// File: rtl/pipelined_add_sub.sv
// WIDTH-bit add/sub split into STAGES carry-chained slices, one slice per cycle,
// with a single global stall enable and optional signed saturation on the last stage.
module pipelined_add_sub
  import add_sub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  input  logic             i_sat,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_ovf,
  output logic             o_zero,
  output logic             o_neg
);
  localparam int SLICE = WIDTH / STAGES;
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(sat_min(WIDTH));

  op_e  op;
  logic adv;
  logic [STAGES:1] vld_pipe;

  // st_* is the input side of stage k: element 0 from the ports, others registered.
  logic [STAGES-1:0][WIDTH-1:0] st_a, st_b, st_sum, nxt_sum;
  logic [STAGES-1:0]            st_c, st_sat, nxt_c;
  logic                         cin_msb, ovf;
  logic [WIDTH-1:0]             res;

  assign op      = op_e'(i_sub);
  assign adv     = ~o_valid | i_ready;
  assign o_ready = adv;
  assign o_valid = vld_pipe[STAGES];

  assign st_a[0]   = i_a;
  assign st_b[0]   = i_b ^ {WIDTH{op == OP_SUB}};
  assign st_sum[0] = '0;
  assign st_c[0]   = (op == OP_SUB);
  assign st_sat[0] = i_sat;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SLICE-1:0] s;
    logic             co, cm;

    add_sub_slice #(.SLICE(SLICE)) u_slice (
      .a       (st_a[k][k*SLICE +: SLICE]),
      .b       (st_b[k][k*SLICE +: SLICE]),
      .cin     (st_c[k]),
      .sum     (s),
      .cout    (co),
      .cin_msb (cm)
    );

    always_comb begin
      nxt_sum[k]                  = st_sum[k];
      nxt_sum[k][k*SLICE +: SLICE] = s;
    end
    assign nxt_c[k] = co;

    if (k == STAGES - 1) begin : g_last
      assign cin_msb = cm;
    end
  end

  // On overflow the sign of A equals the sign of effective B, so A alone picks the clamp side.
  assign ovf = nxt_c[STAGES-1] ^ cin_msb;
  assign res = (st_sat[STAGES-1] & ovf) ? (st_a[STAGES-1][WIDTH-1] ? MIN_V : MAX_V)
                                        : nxt_sum[STAGES-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_pipe <= '0;
      for (int k = 1; k < STAGES; k++) begin
        st_a[k]   <= '0;
        st_b[k]   <= '0;
        st_sum[k] <= '0;
        st_c[k]   <= 1'b0;
        st_sat[k] <= 1'b0;
      end
      o_result <= '0;
      o_carry  <= 1'b0;
      o_ovf    <= 1'b0;
      o_zero   <= 1'b0;
      o_neg    <= 1'b0;
    end else if (adv) begin
      vld_pipe[1] <= i_valid;
      for (int k = 2; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
      for (int k = 1; k < STAGES; k++) begin
        st_a[k]   <= st_a[k-1];
        st_b[k]   <= st_b[k-1];
        st_sum[k] <= nxt_sum[k-1];
        st_c[k]   <= nxt_c[k-1];
        st_sat[k] <= st_sat[k-1];
      end
      o_result <= res;
      o_carry  <= nxt_c[STAGES-1];
      o_ovf    <= ovf;
      o_zero   <= (res == '0);
      o_neg    <= res[WIDTH-1];
    end
  end
endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench: directed vectors, randomized stalled stream vs. arithmetic model, mid-stream reset, 32-bit/4-stage checks.
module tb_pipelined_add_sub;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       v, rdy_o, sub, sat, ov, rdy_i, car, ovf, zr, ng;
  logic [7:0] a, b, res;

  logic        v2, rdy2_o, ov2, car2, ovf2, zr2, ng2;
  logic        sub2, sat2, rdy2_i;
  logic [31:0] a2, b2, res2;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  pipelined_add_sub #(.WIDTH(8), .STAGES(2)) u_dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v), .o_ready(rdy_o), .i_a(a), .i_b(b),
    .i_sub(sub), .i_sat(sat), .o_valid(ov), .i_ready(rdy_i), .o_result(res),
    .o_carry(car), .o_ovf(ovf), .o_zero(zr), .o_neg(ng));

  pipelined_add_sub #(.WIDTH(32), .STAGES(4)) u_dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v2), .o_ready(rdy2_o), .i_a(a2), .i_b(b2),
    .i_sub(sub2), .i_sat(sat2), .o_valid(ov2), .i_ready(rdy2_i), .o_result(res2),
    .o_carry(car2), .o_ovf(ovf2), .o_zero(zr2), .o_neg(ng2));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", nm, act, exp);
    else pass_cnt++;
  endtask

  // Reference: true signed/unsigned arithmetic, then clamp. Returns {result, carry, ovf, zero, neg}.
  function automatic logic [11:0] ref_op(input logic [7:0] ra, input logic [7:0] rb,
                                         input logic rsub, input logic rsat);
    int sa, sb, t, ua, ub, u;
    logic c, o;
    logic [7:0] r;
    sa = $signed(ra); sb = $signed(rb);
    ua = ra;          ub = rb;
    t  = rsub ? sa - sb : sa + sb;
    u  = rsub ? ua - ub + 256 : ua + ub;
    c  = rsub ? (ua >= ub) : (u > 255);
    o  = (t > 127) || (t < -128);
    r  = 8'(u);
    if (rsat && o) r = (t > 0) ? 8'h7F : 8'h80;
    return {r, c, o, (r == 8'h00), r[7]};
  endfunction

  typedef struct {
    logic [7:0] a, b;
    logic       sub, sat;
    logic [7:0] r;
    logic       c, o, z, n;
  } vec_t;
  vec_t tv[8];

  task automatic send8(input string nm, input logic [7:0] ta, input logic [7:0] tb,
                       input logic ts, input logic tsat, input logic [11:0] exp);
    int lat;
    @(posedge clk); #1;
    v = 1'b1; a = ta; b = tb; sub = ts; sat = tsat; rdy_i = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) v = 1'b0;
    end while (!ov && lat < 10);
    chk({nm, "_lat"}, 64'(lat), 64'd2);
    chk(nm, 64'({res, car, ovf, zr, ng}), 64'(exp));
  endtask

  initial begin
    logic [11:0] q[$];
    logic [11:0] e;
    logic [31:0] q32[$];
    int tx, rx, cyc, bad, first_c, last_c, n32, lat;

    rst_n = 1'b0; v = 0; a = 0; b = 0; sub = 0; sat = 0; rdy_i = 1'b1;
    v2 = 0; a2 = 0; b2 = 0; sub2 = 0; sat2 = 0; rdy2_i = 1'b1;
    #12;
    chk("reset_out8", 64'({ov, res, car, ovf, zr, ng}), 64'd0);
    chk("reset_out32", 64'({ov2, res2, car2, ovf2, zr2, ng2}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("reset_ready", 64'({rdy_o, rdy2_o}), 64'b11);

    // r, c, o, z, n are hand-derived from the two's-complement rules.
    tv[0] = '{8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
    tv[2] = '{8'h7F, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[3] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[4] = '{8'h80, 8'h01, 1'b1, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1};
    tv[5] = '{8'h03, 8'h03, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    tv[6] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    tv[7] = '{8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++)
      send8($sformatf("vec%0d", i), tv[i].a, tv[i].b, tv[i].sub, tv[i].sat,
            {tv[i].r, tv[i].c, tv[i].o, tv[i].z, tv[i].n});

    // Random stream with downstream back-pressure; transfers judged at negedge.
    tx = 0; rx = 0; cyc = 0;
    while ((rx < 20) && (cyc < 2000)) begin
      @(posedge clk); #1;
      cyc++;
      v     = (tx < 20) && ($urandom_range(0, 3) != 0);
      a     = 8'($urandom);
      b     = 8'($urandom);
      sub   = 1'($urandom);
      sat   = 1'($urandom);
      rdy_i = 1'($urandom);
      @(negedge clk);
      if (ov && rdy_i) begin
        rx++;
        if (q.size() == 0) chk("stream_extra", 64'(rx), 64'd0);
        else begin
          e = q.pop_front();
          chk($sformatf("stream%0d", rx), 64'({res, car, ovf, zr, ng}), 64'(e));
        end
      end
      if (v && rdy_o) begin
        q.push_back(ref_op(a, b, sub, sat));
        tx++;
      end
    end
    chk("stream_count", 64'(rx), 64'd20);
    chk("stream_leftover", 64'(q.size()), 64'd0);
    @(posedge clk); #1; v = 1'b0; rdy_i = 1'b1;
    repeat (4) @(posedge clk);

    // Fill the pipe, then reset mid-stream.
    #1;
    for (int i = 0; i < 3; i++) begin
      v = 1'b1; a = 8'(8'h40 + i); b = 8'h01; sub = 1'b0; sat = 1'b0;
      @(posedge clk); #1;
    end
    chk("pre_reset_full", 64'(ov), 64'd1);
    rst_n = 1'b0; v = 1'b0;
    #1 chk("rst_ovalid_now", 64'(ov), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ov) bad++;
    end
    chk("post_reset_quiet", 64'(bad), 64'd0);
    send8("post_reset_op", 8'h11, 8'h22, 1'b0, 1'b0, {8'h33, 1'b0, 1'b0, 1'b0, 1'b0});

    // 32-bit, 4 stages: wrap to zero, latency 4.
    @(posedge clk); #1;
    v2 = 1'b1; a2 = 32'hFFFF_FFFF; b2 = 32'h0000_0001; sub2 = 1'b0; sat2 = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) v2 = 1'b0;
    end while (!ov2 && lat < 12);
    chk("w32_lat", 64'(lat), 64'd4);
    chk("w32_wrap", 64'({res2, car2, ovf2, zr2, ng2}), {28'd0, 32'd0, 4'b1010});

    // Back-to-back: 8 inputs on consecutive cycles must emerge on 8 consecutive cycles.
    n32 = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (c < 8) begin
        v2 = 1'b1;
        a2 = 32'(c) * 32'h0101_0101;
        b2 = 32'h00FF_00FF + 32'(c);
        q32.push_back(a2 + b2);
      end else v2 = 1'b0;
      @(negedge clk);
      if (ov2) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        n32++;
        if (q32.size() == 0) chk("w32_extra", 64'(n32), 64'd0);
        else chk($sformatf("w32_b2b%0d", n32), 64'(res2), 64'(q32.pop_front()));
      end
    end
    chk("w32_b2b_count", 64'(n32), 64'd8);
    chk("w32_b2b_first", 64'(first_c), 64'd4);
    chk("w32_b2b_span", 64'(last_c - first_c), 64'd7);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
